conv_viterbi_frame_sequencer: RTL and testbench
===============================================

Name: conv_viterbi_frame_sequencer

Overview:
Frame-level controller between the convolutional-encoder AXI-Stream output and the Viterbi-decoder input of the convolution-to-Viterbi converter stream IP. Counts coded symbol pairs per frame, maps hard bit pairs to offset-binary soft lanes, and appends a configurable run of flush symbols. It also generates decoder TLAST and tracks frame status. Configuration and status connect to the IP's AXI4-Lite slave register bank.

Parameters:
SOFT_WIDTH, 3, soft-decision bits per lane; strong-1 = 2^SOFT_WIDTH-1, strong-0 = 0
LEN_WIDTH, 16, width of frame-length and frame counters
FLUSH_WIDTH, 8, width of flush-length config

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous assert, active-low
cfg_enable  in  1  permit new frames to start
cfg_frame_len  in  LEN_WIDTH  data symbol pairs per frame; 0 treated as 1
cfg_flush_len  in  FLUSH_WIDTH  flush pairs appended per frame
s_axis_tdata  in  2  coded bit pair {G1,G0}
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  encoder end-of-frame marker
s_axis_tready  out  1  input ready
m_axis_tdata  out  16  [7:0] lane0 (G0), [15:8] lane1 (G1), each soft value zero-extended
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last beat of frame, including flush
m_axis_tready  in  1  decoder ready
sts_busy  out  1  state != IDLE
sts_frame_count  out  LEN_WIDTH  completed frames, wraps
sts_err_early  out  1  sticky: s_axis_tlast before frame_len reached
sts_err_late  out  1  sticky: frame_len reached without s_axis_tlast
sts_err_clr  in  1  clear both sticky errors (err_set wins if same cycle)

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Asynchronous reset mid-frame discards the frame and drops m_axis_tvalid immediately.
- State IDLE: if cfg_enable=1, latch cfg_frame_len and cfg_flush_len into shadow registers, clear sym_cnt, and go to RUN next cycle. Config changes mid-frame have no effect.
- State RUN: s_axis_tready = !m_axis_tvalid || m_axis_tready. An input handshake loads the output register the same edge (1-cycle latency). Bit 1 maps to strong-1, bit 0 to 0. sym_cnt increments.
  - Beat with sym_cnt == len-1 or s_axis_tlast=1 ends data. If the beat has tlast=1 and sym_cnt < len-1, set err_early. If sym_cnt == len-1 and tlast=0, set err_late. With flush_len = 0, this beat carries m_axis_tlast and the next state is DONE. Otherwise the next state is FLUSH.
- State FLUSH: s_axis_tready=0. Emits flush_len beats of tdata 0x0000 whenever the output register is free. The final flush beat carries m_axis_tlast. Next state is DONE.
- State DONE: wait until the last beat is accepted (m_axis_tvalid && m_axis_tready). Increment sts_frame_count, wrapping 2^LEN_WIDTH-1 to 0. Go to IDLE. IDLE re-enters RUN the next cycle if cfg_enable is still 1, leaving 1 idle cycle between frames.
- Dropping cfg_enable mid-frame completes the current frame, including flush, then holds in IDLE.
- Output register holds tdata, tvalid, and tlast stable while tvalid && !tready (AXI-Stream rule). Back-to-back throughput is 1 beat per cycle.
- Unused bits of each output byte are 0.

Optional Feature:
CONV_VIT_SEQ_IRQ_EN. Defined: adds output irq (1) and input irq_ack (1). irq is set on the DONE acceptance edge and holds until irq_ack=1; if set and ack coincide, set wins. Reset value of irq is 0. Undefined: neither port exists and there is no irq logic.

Test Plan:
- frame_len=4, flush_len=2, input bits 11,00,10,01 with tlast on the 4th, tready=1 -> out 0x0707,0x0000,0x0700,0x0007,0x0000,0x0000; tlast only on 6th beat; frame_count=1; no errors.
- frame_len=8, tlast on 3rd input, flush_len=1 -> 3 data beats + 1 flush beat, tlast on 4th, sts_err_early=1; sts_err_clr -> 0.
- frame_len=2, flush_len=0, no input tlast -> tlast on 2nd beat, sts_err_late=1.
- m_axis_tready toggles 1010 during 16-pair frame -> no loss or duplication, tdata stable while stalled, 16+flush beats exactly.
- ARESETN low for 1 cycle during FLUSH -> tvalid 0 asynchronously, state IDLE, frame_count unchanged; next frame correct.
- cfg_enable dropped during RUN; with CONV_VIT_SEQ_IRQ_EN defined -> frame finishes, irq=1 until irq_ack, sts_busy=0, no new frame.

Source files
------------

// File: rtl/conv_viterbi_frame_sequencer.sv
// conv_viterbi_frame_sequencer
// Frame-level controller between the convolutional encoder stream and the
// Viterbi decoder input. It counts coded symbol pairs per frame and maps hard
// bit pairs to offset-binary soft lanes. It appends a run of zero flush
// symbols, generates decoder TLAST and tracks frame status.
// Optional feature macro: CONV_VIT_SEQ_IRQ_EN adds a frame-done interrupt
// (irq) with acknowledge (irq_ack).
module conv_viterbi_frame_sequencer #(
  parameter int SOFT_WIDTH  = 3,
  parameter int LEN_WIDTH   = 16,
  parameter int FLUSH_WIDTH = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   cfg_enable,
  input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic [FLUSH_WIDTH-1:0] cfg_flush_len,
  input  logic [1:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [15:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   sts_busy,
  output logic [LEN_WIDTH-1:0]   sts_frame_count,
  output logic                   sts_err_early,
  output logic                   sts_err_late,
  input  logic                   sts_err_clr
`ifdef CONV_VIT_SEQ_IRQ_EN
  ,
  output logic                   irq,
  input  logic                   irq_ack
`endif
);

  localparam logic [7:0]             STRONG_ONE = 8'((1 << SOFT_WIDTH) - 1);
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [FLUSH_WIDTH-1:0] FLUSH_ONE  = FLUSH_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [LEN_WIDTH-1:0]   len_sh;
  logic [FLUSH_WIDTH-1:0] flush_sh;
  logic [LEN_WIDTH-1:0]   sym_cnt;
  logic [FLUSH_WIDTH-1:0] flush_cnt;
  logic [LEN_WIDTH-1:0]   frame_count;
  logic                   err_early;
  logic                   err_late;

  logic [15:0]            tdata_p0;
  logic                   vld_p0;
  logic                   last_p0;

  logic                   out_free;
  logic                   at_len;
  logic                   flush_at_end;
  logic                   in_ready;
  logic                   latch_cfg;
  logic                   load_data;
  logic                   load_flush;
  logic                   set_last;
  logic                   done_acc;
  logic                   err_early_set;
  logic                   err_late_set;

  // Hard bit to soft lane: bit 1 is the strongest "1", bit 0 the strongest "0".
  function automatic logic [7:0] soft_map(input logic b);
    return b ? STRONG_ONE : 8'h00;
  endfunction

  assign out_free     = !vld_p0 || m_axis_tready;
  assign at_len       = (sym_cnt == len_sh - LEN_ONE);
  assign flush_at_end = (flush_cnt == flush_sh - FLUSH_ONE);

  // State register; an abort by reset returns straight to IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    latch_cfg     = 1'b0;
    load_data     = 1'b0;
    load_flush    = 1'b0;
    set_last      = 1'b0;
    done_acc      = 1'b0;
    err_early_set = 1'b0;
    err_late_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable) begin
          latch_cfg = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = out_free;
        if (s_axis_tvalid && out_free) begin
          load_data = 1'b1;
          if (at_len || s_axis_tlast) begin
            // sym_cnt never passes len-1, so "not at_len" means "short frame"
            err_early_set = s_axis_tlast && !at_len;
            err_late_set  = at_len && !s_axis_tlast;
            if (flush_sh == '0) begin
              set_last  = 1'b1;
              state_nxt = DONE;
            end else begin
              state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_flush = 1'b1;
          if (flush_at_end) begin
            set_last  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (vld_p0 && m_axis_tready) begin
          done_acc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shadow config and symbol/flush counters; config only sampled in IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      len_sh    <= '0;
      flush_sh  <= '0;
      sym_cnt   <= '0;
      flush_cnt <= '0;
    end else if (latch_cfg) begin
      len_sh    <= (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
      flush_sh  <= cfg_flush_len;
      sym_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_data)  sym_cnt   <= sym_cnt + LEN_ONE;
      if (load_flush) flush_cnt <= flush_cnt + FLUSH_ONE;
    end
  end

  // Output register stage: loads on a new beat, holds while stalled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tdata_p0 <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else if (load_data) begin
      tdata_p0 <= {soft_map(s_axis_tdata[1]), soft_map(s_axis_tdata[0])};
      vld_p0   <= 1'b1;
      last_p0  <= set_last;
    end else if (load_flush) begin
      tdata_p0 <= '0;
      vld_p0   <= 1'b1;
      last_p0  <= set_last;
    end else if (vld_p0 && m_axis_tready) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end
  end

  // Completed-frame counter (wraps) and sticky errors where setting beats clearing.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_count <= '0;
      err_early   <= 1'b0;
      err_late    <= 1'b0;
    end else begin
      if (done_acc) frame_count <= frame_count + LEN_ONE;
      if (err_early_set)    err_early <= 1'b1;
      else if (sts_err_clr) err_early <= 1'b0;
      if (err_late_set)     err_late  <= 1'b1;
      else if (sts_err_clr) err_late  <= 1'b0;
    end
  end

`ifdef CONV_VIT_SEQ_IRQ_EN
  // Frame-done interrupt: set on the final acceptance, held until acknowledged.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)     irq <= 1'b0;
    else if (done_acc) irq <= 1'b1;
    else if (irq_ack)  irq <= 1'b0;
  end
`endif

  assign s_axis_tready   = in_ready;
  assign m_axis_tdata    = tdata_p0;
  assign m_axis_tvalid   = vld_p0;
  assign m_axis_tlast    = last_p0;
  assign sts_busy        = (state != IDLE);
  assign sts_frame_count = frame_count;
  assign sts_err_early   = err_early;
  assign sts_err_late    = err_late;

endmodule

// File: tb/tb_conv_viterbi_frame_sequencer.sv
// Self-checking bench for conv_viterbi_frame_sequencer: randomized frames
// against a frame-level reference model.
module tb_conv_viterbi_frame_sequencer;

  localparam int SW     = 3;
  localparam int LW     = 16;
  localparam int FW     = 8;
  localparam int STRONG = (1 << SW) - 1;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          cfg_enable;
  logic [LW-1:0] cfg_frame_len;
  logic [FW-1:0] cfg_flush_len;
  logic [1:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [15:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic [LW-1:0] frame_count;
  logic          err_early;
  logic          err_late;
  logic          err_clr;
`ifdef CONV_VIT_SEQ_IRQ_EN
  logic          irq;
  logic          irq_ack;
`endif

  conv_viterbi_frame_sequencer #(.SOFT_WIDTH(SW), .LEN_WIDTH(LW), .FLUSH_WIDTH(FW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_enable(cfg_enable), .cfg_frame_len(cfg_frame_len), .cfg_flush_len(cfg_flush_len),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .sts_busy(busy), .sts_frame_count(frame_count),
    .sts_err_early(err_early), .sts_err_late(err_late), .sts_err_clr(err_clr)
`ifdef CONV_VIT_SEQ_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int          pairs[64];
  int          exp_fc = 0;
  bit          exp_early = 0;
  bit          exp_late = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  // Output monitor: records accepted beats and checks hold-while-stalled.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {15'd0, m_tvalid, m_tlast, m_tdata}, {15'd0, 1'b1, prev_beat});
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      prev_stall <= m_tvalid && !m_tready;
      prev_beat  <= {m_tlast, m_tdata};
    end
  end

  task automatic feed(input int n, input int tl, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int  wc;
      bit  acc;
      if (gaps) begin
        s_tvalid = 1'b0;
        while ($urandom_range(0, 2) == 0) begin
          @(posedge ACLK);
          #1;
        end
      end
      s_tdata  = 2'(pairs[i]);
      s_tvalid = 1'b1;
      s_tlast  = (i == tl);
      acc = 0;
      wc  = 0;
      while (!acc && wc < 300) begin
        @(negedge ACLK);
        acc = s_tready;
        @(posedge ACLK);
        #1;
        wc++;
      end
      if (!acc) timeout("feed");
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_frame(input int len, input int flush, input int tl, input int rmode, input bit gaps);
    int eff, ndata, nexp, wc;
    bit early, late;
    got_q.delete();
    exp_q.delete();
    // Reference: data stops at len or at the first tlast, then zero flush beats.
    eff   = (len == 0) ? 1 : len;
    ndata = (tl >= 0 && tl < eff - 1) ? tl + 1 : eff;
    early = (tl >= 0 && tl < eff - 1);
    late  = (tl != eff - 1) && !early;
    for (int i = 0; i < ndata; i++) begin
      int d;
      d = 0;
      if ((pairs[i] & 2) != 0) d += STRONG * 256;
      if ((pairs[i] & 1) != 0) d += STRONG;
      exp_q.push_back({(i == ndata - 1) && (flush == 0), 16'(d)});
    end
    for (int j = 0; j < flush; j++) exp_q.push_back({(j == flush - 1), 16'h0000});
    nexp = ndata + flush;
    exp_early = exp_early | early;
    exp_late  = exp_late | late;
    exp_fc++;

    cfg_frame_len = LW'(len);
    cfg_flush_len = FW'(flush);
    cfg_enable    = 1'b1;
    @(posedge ACLK);
    #1;
    check("busy_start", {31'd0, busy}, 32'd1);
    cfg_enable    = 1'b0;
    cfg_frame_len = LW'($urandom_range(1, 40));
    cfg_flush_len = FW'($urandom_range(0, 9));
    fork
      feed(ndata, tl, gaps);
      begin
        int cyc;
        cyc = 0;
        while (got_q.size() < nexp && cyc < 3000) begin
          case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 2 == 0);
            default: m_tready = 1'($urandom_range(0, 1));
          endcase
          @(posedge ACLK);
          #1;
          cyc++;
        end
        if (got_q.size() < nexp) timeout("out_beats");
        m_tready = 1'b1;
      end
    join
    wc = 0;
    while (busy && wc < 50) begin
      @(posedge ACLK);
      #1;
      wc++;
    end
    check("beat_count", got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++) check("beat", {15'd0, got_q[i]}, {15'd0, exp_q[i]});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("frame_count", {16'd0, frame_count}, {16'd0, 16'(exp_fc)});
    check("err_early", {31'd0, err_early}, {31'd0, exp_early});
    check("err_late", {31'd0, err_late}, {31'd0, exp_late});
`ifdef CONV_VIT_SEQ_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
    repeat (2) @(posedge ACLK);
    #1;
    check("irq_hold", {31'd0, irq}, 32'd1);
    irq_ack = 1'b1;
    @(posedge ACLK);
    #1;
    irq_ack = 1'b0;
    check("irq_ack", {31'd0, irq}, 32'd0);
`endif
    repeat (3) @(posedge ACLK);
    #1;
    check("idle_hold", {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge ACLK);
    #1;
    err_clr   = 1'b0;
    exp_early = 0;
    exp_late  = 0;
    check("clr_early", {31'd0, err_early}, 32'd0);
    check("clr_late", {31'd0, err_late}, 32'd0);
  endtask

  initial begin
    int wc;
    ARESETN = 1'b0; cfg_enable = 1'b0; cfg_frame_len = '0; cfg_flush_len = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; err_clr = 1'b0;
`ifdef CONV_VIT_SEQ_IRQ_EN
    irq_ack = 1'b0;
`endif
    repeat (3) @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
    #1;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_tdata", {16'd0, m_tdata}, 32'd0);
    check("rst_tready", {31'd0, s_tready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fcount", {16'd0, frame_count}, 32'd0);
    check("rst_errs", {30'd0, err_early, err_late}, 32'd0);

    // Asynchronous reset in the middle of the flush run.
    @(posedge ACLK);
    #1;
    m_tready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) pairs[i] = int'($urandom_range(0, 3));
    cfg_frame_len = 16'd4; cfg_flush_len = 8'd8; cfg_enable = 1'b1;
    @(posedge ACLK);
    #1;
    cfg_enable = 1'b0;
    feed(4, 3, 0);
    wc = 0;
    while (got_q.size() < 6 && wc < 50) begin
      @(negedge ACLK);
      wc++;
    end
    if (got_q.size() < 6) timeout("flush_reach");
    #2;
    ARESETN = 1'b0;
    #1;
    check("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fcount", {16'd0, frame_count}, 32'd0);
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
    got_q.delete();

    // Directed frame: 11,00,10,01 with tlast on the fourth, two flush beats.
    pairs[0] = 3; pairs[1] = 0; pairs[2] = 2; pairs[3] = 1;
    run_frame(4, 2, 3, 0, 0);
    check("tp1_b0", {15'd0, got_q[0]}, 32'h00707);
    check("tp1_b2", {15'd0, got_q[2]}, 32'h00700);
    check("tp1_b3", {15'd0, got_q[3]}, 32'h00007);
    check("tp1_b5", {15'd0, got_q[5]}, 32'h10000);

    // Early tlast, then clear.
    for (int i = 0; i < 64; i++) pairs[i] = int'($urandom_range(0, 3));
    run_frame(8, 1, 2, 0, 0);
    clear_errors();

    // Length reached without tlast, no flush.
    for (int i = 0; i < 64; i++) pairs[i] = int'($urandom_range(0, 3));
    run_frame(2, 0, -1, 0, 0);
    clear_errors();

    // 16-pair frame with tready toggling 1010.
    for (int i = 0; i < 64; i++) pairs[i] = int'($urandom_range(0, 3));
    run_frame(16, 3, 15, 1, 0);

    // Zero frame length behaves as one pair.
    for (int i = 0; i < 64; i++) pairs[i] = int'($urandom_range(0, 3));
    run_frame(0, 1, -1, 0, 0);
    clear_errors();

    // Randomized frames with random backpressure and input gaps.
    for (int f = 0; f < 8; f++) begin
      int len, fl, tl;
      for (int i = 0; i < 64; i++) pairs[i] = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      fl  = int'($urandom_range(0, 4));
      tl  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 13));
      run_frame(len, fl, tl, 2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
